// File: rtl/reg_bus_init.sv
// Register-bus initiator: buffers controller commands in a small FIFO and issues
// each one as a single-cycle cs access, returning read data over valid/ready.
module reg_bus_init #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 32
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rw,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] rsp_addr,
  output logic          busy,
  output logic          cs,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RWAIT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        wait_cnt;
  logic [PW:0]       count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [AW+DW:0]    fifo_mem [DEPTH];
  logic [AW+DW:0]    head;
  logic              full;
  logic              push;
  logic              pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = fifo_mem[rd_ptr];
  assign busy      = (count != '0) | (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (xrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cs        <= 1'b0;
      rw        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else begin
      cs <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            rw    <= head[AW+DW];
            addr  <= head[AW+DW-1:DW];
            wdata <= head[AW+DW] ? head[DW-1:0] : '0;
            cs    <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (rw) begin
            state <= IDLE;
          end else begin
            wait_cnt <= 2'(RD_LAT - 1);
            state    <= RWAIT;
          end
        end
        RWAIT: begin
          if (wait_cnt == '0) begin
            rsp_rdata <= rdata;
            rsp_addr  <= addr;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          // Holding here blocks further bus accesses until the response is taken.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
